sdtw_stream_engine: RTL and testbench
=====================================

Name: sdtw_stream_engine

Overview:
- Second-generation subsequence-DTW systolic engine for squiggle-to-reference matching.
- Adds a runtime query length (≤ SQG_MAX) and valid/ready streaming for query and reference samples, with global stall.
- Uses saturating cost arithmetic and an explicit drain phase, so the last-row minimum is final before done.
- Sits between the sample DMA/stream front-end and the classification logic; one engine per channel.

Parameters:
WIDTH, 16, bit width of samples and DTW costs (unsigned)
SQG_MAX, 250, number of PEs; maximum query length
POS_W, 32, width of reference position and length fields
QL_W, $clog2(SQG_MAX+1), width of the qry_len field

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  one-cycle pulse; latches qry_len and ref_len
qry_len  in  QL_W  query length for this job
ref_len  in  POS_W  reference length for this job
q_data  in  WIDTH  query sample
q_valid  in  1  query sample valid
q_ready  out  1  engine accepts query sample
r_data  in  WIDTH  reference sample
r_valid  in  1  reference sample valid
r_ready  out  1  engine accepts reference sample
busy  out  1  state is not IDLE and not DONE
done  out  1  one-cycle pulse on entry to DONE
err  out  1  bad job parameters; held until next start
min_val  out  WIDTH  best last-row cost
min_pos  out  POS_W  0-based reference index of min_val

Behaviour:
- Reset values: q_ready=0, r_ready=0, busy=0, done=0, err=0, min_val=all ones, min_pos=0, state IDLE. All PE cost registers = all ones; query buffer = 0; valid pipeline cleared.
- Reset mid-job aborts immediately to these values. No partial result is retained.
- FSM states: IDLE, LOAD_Q, RUN, DRAIN, DONE.
- IDLE/DONE + start:
  - If qry_len==0, qry_len>SQG_MAX, or ref_len==0: err=1, go to DONE (done pulses next cycle; min_val/min_pos at reset values).
  - Otherwise: clear cost registers and min tracker, err=0, go to LOAD_Q.
- start is ignored in LOAD_Q, RUN and DRAIN.
- LOAD_Q:
  - q_ready=1.
  - Each q_valid&&q_ready writes q_data to query buffer[idx] and increments idx (from 1).
  - After the qry_len-th sample, go to RUN.
- RUN:
  - r_ready=1.
  - An advance occurs only on r_valid&&r_ready; otherwise the entire array, valid pipeline and tracker hold (global stall).
  - After the ref_len-th accepted sample, go to DRAIN.
- DRAIN:
  - r_ready=0; the array advances every cycle with valid bit 0 injected.
  - Lasts qry_len+2 cycles, which flushes the diagonal and the compare register; then go to DONE.
- DONE: done=1 for exactly the entry cycle. min_val, min_pos and err hold until the next start.
- Array datapath per advance:
  - The reference sample shifts diagonally, PE m receiving it m-1 advances after PE 1.
  - Per-PE valid bit v[m] shifts with the sample.
  - PE m computes cost = sat_add(|x_m - y_m|, min(W, N, NW)).
    - W = own previous cost; N = PE m-1 previous cost; NW = PE m-1 cost from one valid update earlier.
    - PE 1 uses N=NW=0 (free start anywhere in the reference).
  - Cost registers and pprev registers update only when their valid bit is set.
- Arithmetic:
  - |x-y| is computed on unsigned WIDTH-bit values.
  - sat_add clamps to 2^WIDTH-1; no wrap is permitted.
- Last row:
  - A mux taps PE qry_len (runtime), not PE SQG_MAX. PEs beyond qry_len compute harmlessly and are ignored.
  - The tap is registered with its valid bit and a reference index counter.
  - The registered value updates the tracker when valid and strictly less than min_val.
  - Ties therefore keep the earliest position.
  - Reference index counts from 0 and increments per valid last-row output.
- Latency: result final at done, which occurs qry_len+3 cycles after the last reference acceptance when there is no stall.

Decomposition:
- Package sdtw_pkg holds:
  - sat_add and absdiff functions;
  - the state enum;
  - the COST_MAX constant.
- Sub-module sdtw_pe_sat: combinational absdiff + 3-way min + sat_add, WIDTH-parametrised. It is instantiated SQG_MAX times by generate.
- Sequencing and the min tracker remain in the top module.

Test Plan:
- Match: SQG_MAX=4, WIDTH=16, query [10,20,30], ref [0,10,20,30,0] -> done pulse, min_val=0, min_pos=3, err=0.
- Tie: query [10,20,30], ref [10,20,30,10,20,30] -> min_val=0, min_pos=2 (earliest kept).
- Backpressure: match case with r_valid toggled every other cycle and q_valid gaps -> identical result to the match case; no extra samples consumed.
- Saturation: WIDTH=8, query [255,255], ref [0,0] -> min_val=255, min_pos=0, no wrap to small values.
- Error: start with qry_len=0 (also qry_len=5 with SQG_MAX=4, and ref_len=0) -> err=1, q_ready and r_ready never asserted, done one cycle later, min_val=255/all ones.
- Reset mid-RUN, then a new job with the match case -> all outputs return to reset values; the new job gives min_val=0, min_pos=3.

Source files
------------

// File: rtl/sdtw_pkg.sv
// sdtw_pkg: shared state encoding and saturating cost helpers for the subsequence-DTW engine.
package sdtw_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD_Q, S_RUN, S_DRAIN, S_DONE} state_t;
  localparam logic [31:0] COST_MAX = '1;
  function automatic logic [31:0] absdiff(input logic [31:0] a, input logic [31:0] b);
    return a > b ? a - b : b - a;
  endfunction
  // Clamps to 2^w-1 so a saturated cell never wraps into a small, winning cost.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int unsigned w);
    logic [32:0] s;
    logic [32:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (33'd1 << w) - 33'd1;
    return s > m ? m[31:0] : s[31:0];
  endfunction
endpackage

// File: rtl/sdtw_pe_sat.sv
// sdtw_pe_sat: one DTW cell, |x-y| plus the cheapest of west, north and north-west, saturating.
module sdtw_pe_sat
  import sdtw_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic [WIDTH-1:0] i_w,
  input  logic [WIDTH-1:0] i_n,
  input  logic [WIDTH-1:0] i_nw,
  output logic [WIDTH-1:0] o_cost
);
  logic [WIDTH-1:0] w_m1, w_m;
  assign w_m1 = i_w < i_n ? i_w : i_n;
  assign w_m = w_m1 < i_nw ? w_m1 : i_nw;
  assign o_cost = WIDTH'(sat_add(absdiff(32'(i_x), 32'(i_y)), 32'(w_m), WIDTH));
endmodule

// File: rtl/sdtw_stream_engine.sv
// sdtw_stream_engine: streaming subsequence-DTW systolic array with runtime query length,
// global stall on reference backpressure, drain phase and last-row minimum tracker.
module sdtw_stream_engine
  import sdtw_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SQG_MAX = 250,
  parameter int POS_W = 32,
  parameter int QL_W = $clog2(SQG_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [QL_W-1:0]  qry_len,
  input  logic [POS_W-1:0] ref_len,
  input  logic [WIDTH-1:0] q_data,
  input  logic             q_valid,
  output logic             q_ready,
  input  logic [WIDTH-1:0] r_data,
  input  logic             r_valid,
  output logic             r_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] min_val,
  output logic [POS_W-1:0] min_pos
);
  state_t r_st, w_st_n;
  logic [WIDTH-1:0] r_q [SQG_MAX];
  logic [WIDTH-1:0] r_c [SQG_MAX];
  logic [WIDTH-1:0] r_pp [SQG_MAX];
  logic [WIDTH-1:0] r_y [SQG_MAX-1];
  logic [SQG_MAX-2:0] r_v;
  logic [WIDTH-1:0] w_y [SQG_MAX];
  logic [WIDTH-1:0] w_n [SQG_MAX];
  logic [WIDTH-1:0] w_nw [SQG_MAX];
  logic [WIDTH-1:0] w_cost [SQG_MAX];
  logic [SQG_MAX-1:0] w_v;
  logic [QL_W-1:0] r_ql;
  logic [POS_W-1:0] r_rl, r_cnt, r_idx, r_pos;
  logic [WIDTH-1:0] r_min, r_tval, w_tap;
  logic r_tv, w_tap_v, r_err, r_done, w_adv, w_bad, w_go, w_inc;
  assign q_ready = r_st == S_LOAD_Q;
  assign r_ready = r_st == S_RUN;
  assign busy = r_st == S_LOAD_Q || r_st == S_RUN || r_st == S_DRAIN;
  assign done = r_done;
  assign err = r_err;
  assign min_val = r_min;
  assign min_pos = r_pos;
  assign w_adv = (r_st == S_RUN && r_valid) || r_st == S_DRAIN;
  assign w_bad = qry_len == '0 || qry_len > QL_W'(SQG_MAX) || ref_len == '0;
  assign w_go = start && (r_st == S_IDLE || r_st == S_DONE);
  assign w_inc = (r_st == S_LOAD_Q && q_valid) || (r_st == S_RUN && r_valid) || r_st == S_DRAIN;
  genvar m;
  for (m = 0; m < SQG_MAX; m++) begin : g_pe
    if (m == 0) begin : g_first
      // Row 1 starts free anywhere in the reference.
      assign w_y[m] = r_data;
      assign w_v[m] = r_st == S_RUN && r_valid;
      assign w_n[m] = '0;
      assign w_nw[m] = '0;
    end else begin : g_rest
      assign w_y[m] = r_y[m-1];
      assign w_v[m] = r_v[m-1];
      assign w_n[m] = r_c[m-1];
      assign w_nw[m] = r_pp[m-1];
    end
    sdtw_pe_sat #(.WIDTH(WIDTH)) u_pe (
      .i_x(r_q[m]), .i_y(w_y[m]), .i_w(r_c[m]), .i_n(w_n[m]), .i_nw(w_nw[m]), .o_cost(w_cost[m])
    );
  end
  always_comb begin
    w_tap = '1;
    w_tap_v = 1'b0;
    for (int k = 0; k < SQG_MAX; k++) if (r_ql == QL_W'(k + 1)) begin
      w_tap = w_cost[k];
      w_tap_v = w_v[k];
    end
  end
  always_comb begin
    w_st_n = r_st;
    unique case (r_st)
      S_IDLE, S_DONE: w_st_n = start ? (w_bad ? S_DONE : S_LOAD_Q) : r_st;
      S_LOAD_Q: w_st_n = (q_valid && r_cnt == POS_W'(r_ql) - 1'b1) ? S_RUN : r_st;
      S_RUN: w_st_n = (r_valid && r_cnt == r_rl - 1'b1) ? S_DRAIN : r_st;
      S_DRAIN: w_st_n = (r_cnt == POS_W'(r_ql) + 1'b1) ? S_DONE : r_st;
      default: w_st_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st <= S_IDLE;
      r_cnt <= '0;
      r_ql <= '0;
      r_rl <= '0;
      r_err <= 1'b0;
      r_done <= 1'b0;
      r_min <= '1;
      r_pos <= '0;
      r_idx <= '0;
      r_tv <= 1'b0;
      r_tval <= '1;
      r_v <= '0;
      for (int k = 0; k < SQG_MAX; k++) begin
        r_q[k] <= '0;
        r_c[k] <= '1;
        r_pp[k] <= '1;
      end
      for (int k = 0; k < SQG_MAX - 1; k++) r_y[k] <= '0;
    end else begin
      r_st <= w_st_n;
      r_done <= w_st_n == S_DONE && (r_st != S_DONE || start);
      r_cnt <= w_st_n != r_st ? '0 : r_cnt + POS_W'(w_inc);
      if (w_go) begin
        r_ql <= qry_len;
        r_rl <= ref_len;
        r_err <= w_bad;
        r_min <= '1;
        r_pos <= '0;
        r_idx <= '0;
        r_tv <= 1'b0;
        r_v <= '0;
        for (int k = 0; k < SQG_MAX; k++) begin
          r_c[k] <= '1;
          r_pp[k] <= '1;
        end
      end
      if (r_st == S_LOAD_Q && q_valid)
        for (int k = 0; k < SQG_MAX; k++) if (r_cnt == POS_W'(k)) r_q[k] <= q_data;
      if (w_adv) begin
        for (int k = 0; k < SQG_MAX - 1; k++) begin
          r_y[k] <= w_y[k];
          r_v[k] <= w_v[k];
        end
        for (int k = 0; k < SQG_MAX; k++) if (w_v[k]) begin
          r_c[k] <= w_cost[k];
          r_pp[k] <= r_c[k];
        end
        r_tv <= w_tap_v;
        r_tval <= w_tap;
        // Strict less-than keeps the earliest position on ties.
        if (r_tv) begin
          r_idx <= r_idx + 1'b1;
          if (r_tval < r_min) begin
            r_min <= r_tval;
            r_pos <= r_idx;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_sdtw_stream_engine.sv
// tb_sdtw_stream_engine: directed scenarios with hand-computed DTW minima on a 4-PE, 8-bit engine.
module tb_sdtw_stream_engine;
  localparam int W = 8, S = 4, P = 32, QW = 3;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [QW-1:0] qry_len = '0;
  logic [P-1:0] ref_len = '0;
  logic [W-1:0] q_data = '0, r_data = '0;
  logic q_valid = 1'b0, r_valid = 1'b0;
  logic q_ready, r_ready, busy, done, err;
  logic [W-1:0] min_val;
  logic [P-1:0] min_pos;
  logic [W-1:0] qv [8];
  logic [W-1:0] rv [8];
  int checks = 0, failures = 0;
  int q_acc = 0, r_acc = 0, rdy_cnt = 0;
  bit got_done, late;
  sdtw_stream_engine #(.WIDTH(W), .SQG_MAX(S), .POS_W(P), .QL_W(QW)) dut (
    .clk(clk), .rst(rst), .start(start), .qry_len(qry_len), .ref_len(ref_len),
    .q_data(q_data), .q_valid(q_valid), .q_ready(q_ready),
    .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready),
    .busy(busy), .done(done), .err(err), .min_val(min_val), .min_pos(min_pos)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (q_valid && q_ready) q_acc++;
    if (r_valid && r_ready) r_acc++;
    if (q_ready || r_ready) rdy_cnt++;
  end

  task automatic run_job(input int ql, input int rl, input bit gap);
    int t;
    @(negedge clk);
    start = 1'b1; qry_len = QW'(ql); ref_len = P'(rl);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < ql; i++) begin
      if (gap) begin q_valid = 1'b0; @(negedge clk); end
      q_valid = 1'b1; q_data = qv[i]; t = 0;
      while (!q_ready && t < 50) begin @(negedge clk); t++; end
      @(negedge clk);
    end
    q_valid = 1'b0;
    for (int i = 0; i < rl; i++) begin
      if (gap) begin r_valid = 1'b0; @(negedge clk); end
      r_valid = 1'b1; r_data = rv[i]; t = 0;
      while (!r_ready && t < 50) begin @(negedge clk); t++; end
      @(negedge clk);
    end
    r_valid = 1'b0;
    t = 0;
    while (!done && t < 200) begin @(negedge clk); t++; end
    got_done = done;
    @(negedge clk);
    late = done;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({q_ready, r_ready, busy, done, err} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {q_ready, r_ready, busy, done, err});
    end
    checks++;
    if ({min_val, min_pos} !== {8'hFF, 32'd0}) begin
      failures++; $display("FAIL reset_min got val=%0d pos=%0d exp val=255 pos=0", min_val, min_pos);
    end
    rst = 1'b0;
  endtask

  task automatic test_match(input bit gap, input string nm);
    int qa, ra;
    qv = '{10, 20, 30, 0, 0, 0, 0, 0};
    rv = '{0, 10, 20, 30, 0, 0, 0, 0};
    qa = q_acc; ra = r_acc;
    run_job(3, 5, gap);
    checks++;
    if ({got_done, late, err, busy} !== 4'b1000) begin
      failures++; $display("FAIL %s_flags got done=%b late=%b err=%b busy=%b exp 1 0 0 0", nm, got_done, late, err, busy);
    end
    checks++;
    if ({min_val, min_pos} !== {8'd0, 32'd3}) begin
      failures++; $display("FAIL %s_min got val=%0d pos=%0d exp val=0 pos=3", nm, min_val, min_pos);
    end
    checks++;
    if (q_acc - qa !== 3 || r_acc - ra !== 5) begin
      failures++; $display("FAIL %s_accepts got q=%0d r=%0d exp q=3 r=5", nm, q_acc - qa, r_acc - ra);
    end
  endtask

  task automatic test_tie;
    qv = '{10, 20, 30, 0, 0, 0, 0, 0};
    rv = '{10, 20, 30, 10, 20, 30, 0, 0};
    run_job(3, 6, 1'b0);
    checks++;
    if ({got_done, err, min_val, min_pos} !== {1'b1, 1'b0, 8'd0, 32'd2}) begin
      failures++; $display("FAIL tie got done=%b err=%b val=%0d pos=%0d exp 1 0 0 2", got_done, err, min_val, min_pos);
    end
  endtask

  task automatic test_query_lengths;
    qv = '{1, 2, 3, 4, 0, 0, 0, 0};
    rv = '{1, 2, 3, 5, 0, 0, 0, 0};
    run_job(4, 4, 1'b0);
    checks++;
    if ({got_done, min_val, min_pos} !== {1'b1, 8'd1, 32'd2}) begin
      failures++; $display("FAIL full_len got done=%b val=%0d pos=%0d exp 1 1 2", got_done, min_val, min_pos);
    end
    qv = '{5, 0, 0, 0, 0, 0, 0, 0};
    rv = '{9, 7, 100, 0, 0, 0, 0, 0};
    run_job(1, 3, 1'b0);
    checks++;
    if ({got_done, min_val, min_pos} !== {1'b1, 8'd2, 32'd1}) begin
      failures++; $display("FAIL single_len got done=%b val=%0d pos=%0d exp 1 2 1", got_done, min_val, min_pos);
    end
  endtask

  task automatic test_saturation;
    qv = '{255, 255, 0, 0, 0, 0, 0, 0};
    rv = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_job(2, 2, 1'b0);
    checks++;
    if ({got_done, err, min_val, min_pos} !== {1'b1, 1'b0, 8'd255, 32'd0}) begin
      failures++; $display("FAIL saturation got done=%b err=%b val=%0d pos=%0d exp 1 0 255 0", got_done, err, min_val, min_pos);
    end
  endtask

  task automatic test_errors;
    int ql [3] = '{0, 5, 3};
    int rl [3] = '{5, 5, 0};
    int rc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b1; qry_len = QW'(ql[i]); ref_len = P'(rl[i]); rc = rdy_cnt;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({done, err, min_val, min_pos} !== {1'b1, 1'b1, 8'hFF, 32'd0}) begin
        failures++; $display("FAIL err_case%0d_pulse got done=%b err=%b val=%0d pos=%0d exp 1 1 255 0", i, done, err, min_val, min_pos);
      end
      @(negedge clk);
      checks++;
      if ({done, err, busy} !== 3'b010 || rdy_cnt != rc) begin
        failures++; $display("FAIL err_case%0d_after got done=%b err=%b busy=%b readies=%0d exp 0 1 0 0", i, done, err, busy, rdy_cnt - rc);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    qv = '{10, 20, 30, 0, 0, 0, 0, 0};
    rv = '{0, 10, 20, 30, 0, 0, 0, 0};
    @(negedge clk);
    start = 1'b1; qry_len = 3'd3; ref_len = 32'd5;
    @(negedge clk);
    start = 1'b0; q_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin q_data = qv[i]; @(negedge clk); end
    q_valid = 1'b0; r_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin r_data = rv[i]; @(negedge clk); end
    r_valid = 1'b0;
    checks++;
    if ({r_ready, busy, err} !== 3'b110) begin
      failures++; $display("FAIL midrun_state got r_ready=%b busy=%b err=%b exp 1 1 0", r_ready, busy, err);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({q_ready, r_ready, busy, done, err, min_val, min_pos} !== {5'b0, 8'hFF, 32'd0}) begin
      failures++; $display("FAIL midrun_reset got flags=%b val=%0d pos=%0d exp 00000 255 0", {q_ready, r_ready, busy, done, err}, min_val, min_pos);
    end
    rst = 1'b0;
    test_match(1'b0, "after_reset");
  endtask

  initial begin
    test_reset;
    test_match(1'b0, "match");
    test_tie;
    test_match(1'b1, "backpressure");
    test_query_lengths;
    test_saturation;
    test_errors;
    test_reset_mid_run;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
